// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types and helpers for the multiply sequencing controller.
// The select/signedness helpers are sized for MSEQ_XLEN; the controller's XLEN must match it.
package mul_seq_ctrl_pkg;

    localparam int MSEQ_XLEN = 64;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_DRAIN
    } mseq_state_e;

    // Returns {signed_a, signed_b}.
    function automatic logic [1:0] mul_op_signedness(input mul_op_e op);
        logic [1:0] sgn;
        case (op)
            OP_MULHSU: sgn = 2'b10;
            OP_MULHU:  sgn = 2'b00;
            default:   sgn = 2'b11;
        endcase
        return sgn;
    endfunction

    function automatic logic [MSEQ_XLEN-1:0] mul_select(
        input logic [2*MSEQ_XLEN-1:0] product,
        input mul_op_e                op,
        input logic                   word
    );
        logic signed [31:0]           lo32;
        logic signed [MSEQ_XLEN-1:0]  res;
        lo32 = product[31:0];
        if (op == OP_MUL) begin
            if (word) begin
                res = MSEQ_XLEN'(lo32);
            end else begin
                res = product[MSEQ_XLEN-1:0];
            end
        end else begin
            res = product[2*MSEQ_XLEN-1:MSEQ_XLEN];
        end
        return res;
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_prod_cache.sv
// One-entry product cache: key {a, b, signed_a, signed_b} plus the full product.
// Only the valid bit is reset; key and product are qualified by it.
module mul_prod_cache
    import mul_seq_ctrl_pkg::*;
#(
    parameter int XLEN = MSEQ_XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   lk_a,
    input  logic [XLEN-1:0]   lk_b,
    input  logic              lk_signed_a,
    input  logic              lk_signed_b,
    output logic              hit,
    output logic [2*XLEN-1:0] hit_product,
    input  logic              fill,
    input  logic [XLEN-1:0]   fill_a,
    input  logic [XLEN-1:0]   fill_b,
    input  logic              fill_signed_a,
    input  logic              fill_signed_b,
    input  logic [2*XLEN-1:0] fill_product,
    input  logic              inv
);

    logic                  valid_q;
    logic [2*XLEN+1:0]     key_q;
    logic [2*XLEN-1:0]     product_q;
    logic [2*XLEN+1:0]     lk_key;

    assign lk_key      = {lk_a, lk_b, lk_signed_a, lk_signed_b};
    assign hit         = valid_q && (key_q == lk_key);
    assign hit_product = product_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (inv) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            key_q     <= {fill_a, fill_b, fill_signed_a, fill_signed_b};
            product_q <= fill_product;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer between EX and the shared multi-cycle multiplier: issues ops, waits for
// the product, selects/sign-adjusts the result and reuses the last product on a key match.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int XLEN     = MSEQ_XLEN,
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic              req_word,
    input  logic [XLEN-1:0]   req_a,
    input  logic [XLEN-1:0]   req_b,
    input  logic              flush,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic [XLEN-1:0]   mul_a,
    output logic [XLEN-1:0]   mul_b,
    output logic              mul_signed_a,
    output logic              mul_signed_b,
    output logic              mul_start,
    input  logic [2*XLEN-1:0] mul_result,
    input  logic              mul_ready,
    output logic              busy
);

    mseq_state_e       state_q, state_d;
    mul_op_e           op_p0, op_p1;
    logic [1:0]        sgn_p0;
    logic              word_p1;
    logic              accept;
    logic              cache_hit_raw, hit;
    logic [2*XLEN-1:0] cache_product;
    logic              wait_done;

    assign op_p0     = mul_op_e'(req_op);
    assign sgn_p0    = mul_op_signedness(op_p0);
    assign req_ready = (state_q == ST_IDLE) && !flush;
    assign accept    = req_valid && req_ready;
    assign hit       = CACHE_EN && cache_hit_raw;
    assign busy      = (state_q != ST_IDLE);
    assign wait_done = (state_q == ST_WAIT) && mul_ready && !flush;

    mul_prod_cache #(.XLEN(XLEN)) u_cache (
        .clk           (clk),
        .rst           (rst),
        .lk_a          (req_a),
        .lk_b          (req_b),
        .lk_signed_a   (sgn_p0[1]),
        .lk_signed_b   (sgn_p0[0]),
        .hit           (cache_hit_raw),
        .hit_product   (cache_product),
        .fill          (CACHE_EN && wait_done),
        .fill_a        (mul_a),
        .fill_b        (mul_b),
        .fill_signed_a (mul_signed_a),
        .fill_signed_b (mul_signed_b),
        .fill_product  (mul_result),
        .inv           (1'b0)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept stage: operands go to the multiplier on a miss; a hit resolves immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a        <= '0;
            mul_b        <= '0;
            mul_signed_a <= 1'b0;
            mul_signed_b <= 1'b0;
            resp_data    <= '0;
        end else begin
            if (accept && !hit) begin
                mul_a        <= req_a;
                mul_b        <= req_b;
                mul_signed_a <= sgn_p0[1];
                mul_signed_b <= sgn_p0[0];
            end
            if (accept && hit) begin
                resp_data <= mul_select(cache_product, op_p0, req_word);
            end else if (wait_done) begin
                resp_data <= mul_select(mul_result, op_p1, word_p1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p1   <= op_p0;
            word_p1 <= req_word;
        end
    end

    always_comb begin
        state_d    = state_q;
        mul_start  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = hit ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_start = 1'b1;
                state_d   = flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush) begin
                    state_d = mul_ready ? ST_IDLE : ST_DRAIN;
                end else if (mul_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A flushed result must not be taken by the consumer in the same cycle.
                resp_valid = !flush;
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (mul_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Sequencing controller between the EX stage and the shared 64x64 multi-cycle multiplier.
- Accepts RV64M multiply ops (MUL, MULH, MULHSU, MULHU, MULW) over a valid/ready handshake.
- Drives the multiplier's start and signedness inputs, waits for its ready pulse, then selects and sign-adjusts the result half.
- Holds a one-entry product cache so a MULH/MUL pair on the same operands costs one multiplier run. Handles pipeline flush while the multiplier is busy.

Parameters:
- XLEN, 64, operand width; the multiplier product is 2*XLEN.
- CACHE_EN, 1, enables the one-entry product cache; 0 forces every request to the multiplier.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  EX presents a multiply op
- req_ready  out  1  controller accepts the op this cycle
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_word  in  1  MULW; legal only with req_op=00
- req_a  in  XLEN  rs1 value
- req_b  in  XLEN  rs2 value
- flush  in  1  kill the in-flight op
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes the result
- resp_data  out  XLEN  rd value
- mul_a, mul_b  out  XLEN  multiplier operands (registered)
- mul_signed_a, mul_signed_b  out  1  signedness flags
- mul_start  out  1  single-cycle start pulse
- mul_result  in  2*XLEN  multiplier product
- mul_ready  in  1  one-cycle product-valid pulse
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Reset:
  - State goes to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_data=0, mul_start=0, mul_a=mul_b=0, mul_signed_*=0, busy=0.
  - Cache is invalidated.
- req_ready = (state==IDLE) && !flush. Accept occurs on req_valid && req_ready.
- Signedness per op:
  - MUL and MULW: 1,1.
  - MULH: 1,1.
  - MULHSU: 1,0.
  - MULHU: 0,0.
- Cache key = {a, b, signed_a, signed_b}. Hit = CACHE_EN && cache_valid && key match.
- Accept with hit: go to DONE next cycle; resp_data is computed from the cached product. The multiplier is not touched.
- Accept with miss: latch operands and flags into mul_*, then go to ISSUE.
- ISSUE: mul_start=1 for exactly this cycle, then go to WAIT.
- WAIT: hold mul_* stable. On mul_ready:
  - Capture mul_result into the cache (valid=1, new key).
  - Register resp_data.
  - Go to DONE.
  - resp_valid rises the cycle after mul_ready.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2*XLEN-1:XLEN].
  - MULW: sign-extend product[31:0] to XLEN. The cache key uses the raw 64-bit operands.
- DONE: resp_valid=1 and resp_data is stable until resp_ready. On resp_ready go to IDLE; the next request can be accepted the following cycle.
- mul_ready outside WAIT/DRAIN is ignored.
- Flush handling (flush wins over every other event in the same cycle):
  - IDLE: nothing is accepted.
  - ISSUE: the start pulse has already been emitted; go to DRAIN.
  - WAIT without mul_ready: go to DRAIN.
  - WAIT with mul_ready the same cycle: discard the product, do not fill the cache, go to IDLE.
  - DONE: drop resp_valid, go to IDLE; the cache keeps its contents.
- DRAIN: req_ready=0, resp_valid=0. On mul_ready discard the product, do not fill the cache, go to IDLE. A flush in DRAIN has no further effect.
- Reset mid-operation returns to IDLE immediately. The multiplier shares rst, so no drain is needed.
- Latency:
  - Hit: accept-to-resp_valid = 1 cycle.
  - Miss: 1 (ISSUE) + multiplier latency + 1.

Decomposition:
- Shared package holds:
  - mul_op_e enum (MUL, MULH, MULHSU, MULHU).
  - mseq_state_e enum.
  - Function mul_op_signedness(op) returning {signed_a, signed_b}.
  - Function mul_select(product, op, word) returning the XLEN result.
- Natural sub-module: mul_prod_cache (one-entry key/product register with hit compare and fill/invalidate ports).

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD), cache cold -> exactly one mul_start pulse with flags 1,1; resp_data=0xFFFF_FFFF_FFFF_FFEB one cycle after mul_ready.
- MULH then MUL, both a=0x8000_0000_0000_0000, b=2 -> MULH returns 0xFFFF_FFFF_FFFF_FFFF; MUL hits with no mul_start; resp_valid 1 cycle after accept; resp_data=0.
- MULW a=0x0000_0001_7FFF_FFFF, b=2 -> resp_data=0xFFFF_FFFF_FFFF_FFFE.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> flags 0,0; resp_data=0xFFFF_FFFF_FFFF_FFFE. Immediately follow with MULH on the same operands -> cache miss, new mul_start.
- Flush 5 cycles into WAIT -> DRAIN, req_ready=0 until mul_ready, no resp_valid, cache unchanged. A same-operand request afterwards misses.
- Hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data stable, req_ready=0. Assert rst mid-WAIT -> all outputs return to reset values asynchronously.
